imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage. Accepts one raw instruction word per valid/ready handshake and returns its XLEN-wide immediate plus a format tag one cycle later. Extends the combinational RV32I immediate decoding with XLEN=64, compressed (RVC) immediates and CSR zimm, and adds a skid buffer so `ready_o` is registered and full throughput holds under back-pressure.

---
 rtl/riscv_imm_pkg.sv | 35 +++
 rtl/imm_decode_comb.sv | 119 +++++++++++
 rtl/imm_gen_pipe.sv | 114 +++++++++++
 tb/tb_imm_gen_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_imm_pkg
// Description : Shared constants for RISC-V immediate decoding (format tags,
//               major opcodes on instr[6:2], RVC quadrants).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_imm_pkg;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_C    = 3'd7;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_OPIMM32 = 5'b00110;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/imm_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_comb
// Description : Combinational map from a raw instruction word to its
//               XLEN-wide immediate and format tag (RV32/64 base, RVC, zimm).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_comb
    import riscv_imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RVC_EN   = 1,
    parameter int ZICSR_EN = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    // Every immediate fits in 32 bits, and the zero-extended ones never set
    // bit 31, so widening to 64 is always a sign-extension from bit 31.
    logic [31:0] w_imm32;
    logic [2:0]  w_fmt;
    logic [2:0]  w_f3;

    logic [31:0] w_i_imm, w_s_imm, w_b_imm, w_u_imm, w_j_imm, w_z_imm;
    logic [31:0] w_c_addi4spn, w_c_lwsw, w_c_addi, w_c_addi16sp, w_c_lui;
    logic [31:0] w_c_j, w_c_b, w_c_lwsp, w_c_swsp;

    assign w_f3    = instr[15:13];
    assign w_i_imm = {{20{instr[31]}}, instr[31:20]};
    assign w_s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_u_imm = {instr[31:12], 12'b0};
    assign w_j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_z_imm = {27'b0, instr[19:15]};

    assign w_c_addi4spn = {22'b0, instr[10:7], instr[12:11], instr[5], instr[6], 2'b0};
    assign w_c_lwsw     = {25'b0, instr[5], instr[12:10], instr[6], 2'b0};
    assign w_c_addi     = {{26{instr[12]}}, instr[12], instr[6:2]};
    assign w_c_addi16sp = {{22{instr[12]}}, instr[12], instr[4:3], instr[5], instr[2],
                           instr[6], 4'b0};
    assign w_c_lui      = {{14{instr[12]}}, instr[12], instr[6:2], 12'b0};
    assign w_c_j        = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                           instr[7], instr[2], instr[11], instr[5:3], 1'b0};
    assign w_c_b        = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                           instr[4:3], 1'b0};
    assign w_c_lwsp     = {24'b0, instr[3:2], instr[12], instr[6:4], 2'b0};
    assign w_c_swsp     = {24'b0, instr[8:7], instr[12:9], 2'b0};

    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_NONE;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:2])
                OP_LUI, OP_AUIPC:          begin w_imm32 = w_u_imm; w_fmt = FMT_U; end
                OP_JAL:                    begin w_imm32 = w_j_imm; w_fmt = FMT_J; end
                OP_JALR, OP_LOAD, OP_OPIMM: begin w_imm32 = w_i_imm; w_fmt = FMT_I; end
                OP_BRANCH:                 begin w_imm32 = w_b_imm; w_fmt = FMT_B; end
                OP_STORE:                  begin w_imm32 = w_s_imm; w_fmt = FMT_S; end
                OP_OPIMM32: begin
                    if (XLEN == 64) begin
                        w_imm32 = w_i_imm;
                        w_fmt   = FMT_I;
                    end
                end
                OP_SYSTEM: begin
                    if (ZICSR_EN != 0 && instr[14]) begin
                        w_imm32 = w_z_imm;
                        w_fmt   = FMT_Z;
                    end
                end
                default: ;
            endcase
        end else if (RVC_EN != 0) begin
            w_fmt = FMT_C;
            case (instr[1:0])
                Q0: begin
                    case (w_f3)
                        3'b000:         w_imm32 = w_c_addi4spn;
                        3'b010, 3'b110: w_imm32 = w_c_lwsw;
                        default: ;
                    endcase
                end
                Q1: begin
                    case (w_f3)
                        3'b000, 3'b010: w_imm32 = w_c_addi;
                        // f3=001 is C.ADDIW on RV64 but C.JAL on RV32
                        3'b001:         w_imm32 = (XLEN == 64) ? w_c_addi : w_c_j;
                        3'b011:         w_imm32 = (instr[11:7] == 5'd2) ? w_c_addi16sp : w_c_lui;
                        3'b101:         w_imm32 = w_c_j;
                        3'b110, 3'b111: w_imm32 = w_c_b;
                        default: ;
                    endcase
                end
                Q2: begin
                    case (w_f3)
                        3'b010:  w_imm32 = w_c_lwsp;
                        3'b110:  w_imm32 = w_c_swsp;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign imm = w_imm32;
        end
    endgenerate

    assign fmt = w_fmt;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered immediate generator with valid/ready handshake and
//               a skid buffer so ready_o comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RVC_EN   = 1,
    parameter int ZICSR_EN = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [31:0]     instr_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_full  = 2'd1;
    localparam logic [1:0] c_skid  = 2'd2;

    logic [1:0]      r_state;
    logic            r_ready;
    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_fmt;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;

    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_fmt;
    logic            w_accept;
    logic            w_consume;

    imm_decode_comb #(
        .XLEN     (XLEN),
        .RVC_EN   (RVC_EN),
        .ZICSR_EN (ZICSR_EN)
    ) u_decode (
        .instr (instr_i),
        .imm   (w_dec_imm),
        .fmt   (w_dec_fmt)
    );

    assign w_accept  = valid_i && r_ready;
    assign w_consume = r_valid && ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= c_empty;
            r_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_imm      <= '0;
            r_fmt      <= FMT_NONE;
            r_skid_imm <= '0;
            r_skid_fmt <= FMT_NONE;
        end else begin
            case (r_state)
                c_empty: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_imm   <= w_dec_imm;
                        r_fmt   <= w_dec_fmt;
                        r_valid <= 1'b1;
                        r_state <= c_full;
                    end
                end
                c_full: begin
                    if (w_accept && w_consume) begin
                        r_imm <= w_dec_imm;
                        r_fmt <= w_dec_fmt;
                    end else if (w_accept) begin
                        // Output is stalled: park the new result and stop upstream
                        r_skid_imm <= w_dec_imm;
                        r_skid_fmt <= w_dec_fmt;
                        r_ready    <= 1'b0;
                        r_state    <= c_skid;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                        r_state <= c_empty;
                    end
                end
                c_skid: begin
                    if (w_consume) begin
                        r_imm   <= r_skid_imm;
                        r_fmt   <= r_skid_fmt;
                        r_ready <= 1'b1;
                        r_state <= c_full;
                    end
                end
                default: begin
                    r_state <= c_empty;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign imm_o   = r_imm;
    assign fmt_o   = r_fmt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe in three configurations
//               (RV32+RVC, RV64+RVC, RV32 without RVC) sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        valid_in;
    logic        ready_in;

    logic [31:0] imm0, imm2;
    logic [63:0] imm1;
    logic [2:0]  fmt0, fmt1, fmt2;
    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;

    logic [63:0] got_imm [3];
    logic [2:0]  got_fmt [3];
    logic        got_rdy [3];
    logic        got_vld [3];

    int xl [3] = '{32, 64, 32};
    int rv [3] = '{1, 1, 0};

    int n_run  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    bit mon_en = 0;

    logic [31:0] sbw  [3][4];
    int          head [3] = '{0, 0, 0};
    int          tail [3] = '{0, 0, 0};

    imm_gen_pipe #(.XLEN(32), .RVC_EN(1), .ZICSR_EN(1)) u_x32 (
        .clk_i(clk), .reset_i(reset), .instr_i(instr), .valid_i(valid_in),
        .ready_o(rdy0), .imm_o(imm0), .fmt_o(fmt0), .valid_o(vld0), .ready_i(ready_in));
    imm_gen_pipe #(.XLEN(64), .RVC_EN(1), .ZICSR_EN(1)) u_x64 (
        .clk_i(clk), .reset_i(reset), .instr_i(instr), .valid_i(valid_in),
        .ready_o(rdy1), .imm_o(imm1), .fmt_o(fmt1), .valid_o(vld1), .ready_i(ready_in));
    imm_gen_pipe #(.XLEN(32), .RVC_EN(0), .ZICSR_EN(1)) u_norvc (
        .clk_i(clk), .reset_i(reset), .instr_i(instr), .valid_i(valid_in),
        .ready_o(rdy2), .imm_o(imm2), .fmt_o(fmt2), .valid_o(vld2), .ready_i(ready_in));

    assign got_imm[0] = {32'b0, imm0};
    assign got_imm[1] = imm1;
    assign got_imm[2] = {32'b0, imm2};
    assign got_fmt[0] = fmt0;
    assign got_fmt[1] = fmt1;
    assign got_fmt[2] = fmt2;
    assign got_rdy[0] = rdy0;
    assign got_rdy[1] = rdy1;
    assign got_rdy[2] = rdy2;
    assign got_vld[0] = vld0;
    assign got_vld[1] = vld1;
    assign got_vld[2] = vld2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        logic [31:0] s;
        s = w >> lo;
        return longint'(s) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Reference: immediate value as a signed integer built from weighted fields
    function automatic logic [66:0] ref_dec(input logic [31:0] w, input int xlen, input int rvc);
        longint v;
        int     f;
        int     f3;
        v  = 0;
        f  = 0;
        f3 = int'(fld(w, 15, 13));
        if (w[1:0] == 2'b11) begin
            case (int'(fld(w, 6, 2)))
                'h0D, 'h05: begin f = 4; v = fld(w, 31, 12) * 4096 - fld(w, 31, 31) * (longint'(1) << 32); end
                'h1B: begin f = 5; v = fld(w, 30, 21) * 2 + fld(w, 20, 20) * 2048 + fld(w, 19, 12) * 4096
                                    - fld(w, 31, 31) * (longint'(1) << 20); end
                'h19, 'h00, 'h04: begin f = 1; v = fld(w, 31, 20) - fld(w, 31, 31) * 4096; end
                'h06: if (xlen == 64) begin f = 1; v = fld(w, 31, 20) - fld(w, 31, 31) * 4096; end
                'h18: begin f = 3; v = fld(w, 11, 8) * 2 + fld(w, 30, 25) * 32 + fld(w, 7, 7) * 2048
                                    - fld(w, 31, 31) * 4096; end
                'h08: begin f = 2; v = fld(w, 31, 25) * 32 + fld(w, 11, 7) - fld(w, 31, 31) * 4096; end
                'h1C: if (w[14]) begin f = 6; v = fld(w, 19, 15); end
                default: ;
            endcase
        end else if (rvc != 0) begin
            f = 7;
            if (w[1:0] == 2'b00 && f3 == 0)
                v = fld(w, 12, 11) * 16 + fld(w, 10, 7) * 64 + fld(w, 6, 6) * 4 + fld(w, 5, 5) * 8;
            else if (w[1:0] == 2'b00 && (f3 == 2 || f3 == 6))
                v = fld(w, 12, 10) * 8 + fld(w, 6, 6) * 4 + fld(w, 5, 5) * 64;
            else if (w[1:0] == 2'b01 && (f3 == 0 || f3 == 2 || (f3 == 1 && xlen == 64)))
                v = fld(w, 6, 2) - fld(w, 12, 12) * 32;
            else if (w[1:0] == 2'b01 && f3 == 3 && fld(w, 11, 7) == 2)
                v = fld(w, 6, 6) * 16 + fld(w, 5, 5) * 64 + fld(w, 4, 3) * 128 + fld(w, 2, 2) * 32
                    - fld(w, 12, 12) * 512;
            else if (w[1:0] == 2'b01 && f3 == 3)
                v = fld(w, 6, 2) * 4096 - fld(w, 12, 12) * (longint'(1) << 17);
            else if (w[1:0] == 2'b01 && (f3 == 5 || (f3 == 1 && xlen == 32)))
                v = fld(w, 11, 11) * 16 + fld(w, 10, 9) * 256 + fld(w, 8, 8) * 1024 + fld(w, 7, 7) * 64
                    + fld(w, 6, 6) * 128 + fld(w, 5, 3) * 2 + fld(w, 2, 2) * 32 - fld(w, 12, 12) * 2048;
            else if (w[1:0] == 2'b01 && (f3 == 6 || f3 == 7))
                v = fld(w, 11, 10) * 8 + fld(w, 6, 5) * 64 + fld(w, 4, 3) * 2 + fld(w, 2, 2) * 32
                    - fld(w, 12, 12) * 256;
            else if (w[1:0] == 2'b10 && f3 == 2)
                v = fld(w, 12, 12) * 32 + fld(w, 6, 4) * 4 + fld(w, 3, 2) * 64;
            else if (w[1:0] == 2'b10 && f3 == 6)
                v = fld(w, 12, 9) * 4 + fld(w, 8, 7) * 64;
        end
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {f[2:0], v};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  ops [11];
        ops = '{5'h0D, 5'h05, 5'h1B, 5'h19, 5'h00, 5'h04, 5'h06, 5'h18, 5'h08, 5'h1C, 5'h00};
        r = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            r[1:0] = 2'($urandom_range(0, 2));
        end else begin
            ops[10] = 5'($urandom);
            r[6:0] = {ops[$urandom_range(0, 10)], 2'b11};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] w);
        logic [66:0] e;
        for (int k = 0; k < 3; k++) begin
            e = ref_dec(w, xl[k], rv[k]);
            check($sformatf("%s_vld%0d", tag, k), {63'b0, got_vld[k]}, 64'd1);
            check($sformatf("%s_imm%0d", tag, k), got_imm[k], e[63:0]);
            check($sformatf("%s_fmt%0d", tag, k), {61'b0, got_fmt[k]}, {61'b0, e[66:64]});
        end
    endtask

    task automatic expect_idle(input string tag, input logic rdy);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_vld%0d", tag, k), {63'b0, got_vld[k]}, 64'd0);
            check($sformatf("%s_rdy%0d", tag, k), {63'b0, got_rdy[k]}, {63'b0, rdy});
        end
    endtask

    // Scoreboard: outstanding words per instance, checked as they are consumed
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                int          cnt;
                logic [66:0] e;
                cnt = tail[k] - head[k];
                check($sformatf("rnd_rdy%0d", k), {63'b0, got_rdy[k]}, {63'b0, cnt < 2});
                check($sformatf("rnd_vld%0d", k), {63'b0, got_vld[k]}, {63'b0, cnt > 0});
                if (got_vld[k] && ready_in && cnt > 0) begin
                    e = ref_dec(sbw[k][head[k] % 4], xl[k], rv[k]);
                    check($sformatf("rnd_imm%0d", k), got_imm[k], e[63:0]);
                    check($sformatf("rnd_fmt%0d", k), {61'b0, got_fmt[k]}, {61'b0, e[66:64]});
                    head[k]++;
                end
                if (valid_in && got_rdy[k]) begin
                    sbw[k][tail[k] % 4] = instr;
                    tail[k]++;
                    if (k == 0) n_acc++;
                end
            end
        end
    end

    logic [31:0] dir_w   [9] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h3002D073,
                                 32'h123452B7, 32'h0000557D, 32'h123452B7, 32'h800002B7,
                                 32'h0000557D};
    int          dir_k   [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 2};
    logic [63:0] dir_imm [9] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'h8, 64'h5, 64'h12345000,
                                 64'hFFFFFFFF, 64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h0};
    logic [2:0]  dir_fmt [9] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd4, 3'd7, 3'd4, 3'd4, 3'd0};

    initial begin
        logic acc;
        int   cyc;
        reset    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        instr    = '0;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_imm%0d", k), got_imm[k], 64'd0);
            check($sformatf("rst_fmt%0d", k), {61'b0, got_fmt[k]}, 64'd0);
        end
        expect_idle("rst", 1'b0);
        reset = 1'b0;
        step();
        expect_idle("rst_rel", 1'b1);

        // Directed vectors: result must be present right after the accept edge
        for (int i = 0; i < 9; i++) begin
            instr    = dir_w[i];
            valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            expect_all($sformatf("dir%0d", i), dir_w[i]);
            check($sformatf("dir%0d_const_imm", i), got_imm[dir_k[i]], dir_imm[i]);
            check($sformatf("dir%0d_const_fmt", i), {61'b0, got_fmt[dir_k[i]]}, {61'b0, dir_fmt[i]});
        end
        step();
        expect_idle("dir_end", 1'b1);

        // Back-pressure: two words fill output+skid, third is held off
        ready_in = 1'b0;
        valid_in = 1'b1;
        instr    = 32'hFFF00093;
        step();
        expect_all("bp_w0a", 32'hFFF00093);
        for (int k = 0; k < 3; k++) check($sformatf("bp_rdy1_%0d", k), {63'b0, got_rdy[k]}, 64'd1);
        instr = 32'h00000463;
        step();
        expect_all("bp_w0b", 32'hFFF00093);
        for (int k = 0; k < 3; k++) check($sformatf("bp_rdy0_%0d", k), {63'b0, got_rdy[k]}, 64'd0);
        instr = 32'h123452B7;
        step();
        expect_all("bp_hold", 32'hFFF00093);
        ready_in = 1'b1;
        step();
        expect_all("bp_w1", 32'h00000463);
        step();
        expect_all("bp_w2", 32'h123452B7);
        valid_in = 1'b0;
        step();
        expect_idle("bp_done", 1'b1);

        // Reset while in SKID
        ready_in = 1'b0;
        valid_in = 1'b1;
        instr    = 32'hFE20AE23;
        step();
        instr = 32'h3002D073;
        step();
        for (int k = 0; k < 3; k++) check($sformatf("sk_rdy%0d", k), {63'b0, got_rdy[k]}, 64'd0);
        valid_in = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sk_rst_imm%0d", k), got_imm[k], 64'd0);
            check($sformatf("sk_rst_fmt%0d", k), {61'b0, got_fmt[k]}, 64'd0);
        end
        expect_idle("sk_rst", 1'b0);
        step();
        expect_idle("sk_rel", 1'b1);
        ready_in = 1'b1;
        step();
        expect_idle("sk_stale", 1'b1);

        // Random traffic with random valid/ready; upstream holds unaccepted words
        mon_en = 1'b1;
        cyc    = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            acc = valid_in && got_rdy[0];
            step();
            if (!valid_in || acc) begin
                valid_in = ($urandom_range(0, 3) != 0);
                instr    = rand_instr();
            end
            ready_in = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("rnd_accepts", {63'b0, n_acc >= 10000}, 64'd1);
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (5) step();
        mon_en = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("drain%0d", k), 64'(tail[k] - head[k]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
